tagged_operand_queue: RTL and testbench

- Parametrised in-order issue queue for the Tomasulo backend; successor to the single-operand, single-broadcast queue.
- Each entry holds an opcode and two source operands. Each operand is either a value (label 0) or a pending producer label.
- All entries snoop NUM_BC common-data-bus broadcast channels; a matching label is replaced by the broadcast value.
- The head entry issues to the functional unit through a require/requireAC handshake only when both operands are resolved.

---
 rtl/tagged_operand_queue.sv | 184 ++++++++++++++++++
 tb/tb_tagged_operand_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tagged_operand_queue.sv
// tagged_operand_queue: in-order issue queue with two tagged source operands.
// Every queued entry snoops NUM_BC result broadcast channels. An operand with a
// nonzero producer label is replaced by the broadcast value when a channel
// carries that label. The head entry is offered to the functional unit through
// the require/requireAC handshake once both of its operands are resolved.
// Optional build macro: TAGGED_QUEUE_FLUSH_EN adds a synchronous flush input.
module tagged_operand_queue #(
  parameter int DW     = 32,
  parameter int LW     = 5,
  parameter int OPW    = 4,
  parameter int DEPTH  = 8,
  parameter int NUM_BC = 2
) (
  input  logic                    clk,
  input  logic                    nRST,
`ifdef TAGGED_QUEUE_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic                    WEN,
  input  logic [OPW-1:0]          opIN,
  input  logic [DW-1:0]           dataInA,
  input  logic [LW-1:0]           labelInA,
  input  logic [DW-1:0]           dataInB,
  input  logic [LW-1:0]           labelInB,
  output logic                    isFull,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [NUM_BC-1:0]       BCEN,
  input  logic [NUM_BC*LW-1:0]    BClabel,
  input  logic [NUM_BC*DW-1:0]    BCdata,
  output logic                    require,
  input  logic                    requireAC,
  output logic [OPW-1:0]          opOut,
  output logic [DW-1:0]           dataOutA,
  output logic [DW-1:0]           dataOutB,
  output logic [2*LW-1:0]         labelOut
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [LW-1:0]  la;
    logic [DW-1:0]  da;
    logic [LW-1:0]  lb;
    logic [DW-1:0]  db;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  entry_t          head_ent_s;
  entry_t          push_ent_s;
  logic            head_valid_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            flush_s;

  // Resolve one operand against the broadcast channels. A resolved operand
  // (label 0) is left untouched, so a label-0 broadcast can never match.
  // Scanning from the highest channel down lets the lowest index win.
  function automatic logic [LW+DW-1:0] snoop_operand(
    input logic [LW-1:0]        lbl,
    input logic [DW-1:0]        dat,
    input logic [NUM_BC-1:0]    en,
    input logic [NUM_BC*LW-1:0] bl,
    input logic [NUM_BC*DW-1:0] bd
  );
    logic [LW+DW-1:0] res;
    res = {lbl, dat};
    if (lbl != {LW{1'b0}}) begin
      for (int i = NUM_BC - 1; i >= 0; i--) begin
        if (en[i] && (bl[i*LW +: LW] == lbl)) begin
          res = {{LW{1'b0}}, bd[i*DW +: DW]};
        end else begin
          res = res;
        end
      end
    end else begin
      res = res;
    end
    return res;
  endfunction

`ifdef TAGGED_QUEUE_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign head_ent_s   = ent_q[head_q];
  assign head_valid_s = valid_q[head_q];
  assign full_s       = (count_q == CW'(DEPTH));
  // Issue needs both head operands resolved; flush suppresses issue outright.
  assign require      = head_valid_s && (head_ent_s.la == {LW{1'b0}}) &&
                        (head_ent_s.lb == {LW{1'b0}}) && !flush_s;
  // Fullness is judged before any same-cycle pop: a full queue never accepts.
  assign push_s       = WEN && !full_s;
  assign pop_s        = require && requireAC;

  assign isFull   = full_s;
  assign count    = count_q;
  assign opOut    = head_valid_s ? head_ent_s.op : {OPW{1'b0}};
  assign dataOutA = head_valid_s ? head_ent_s.da : {DW{1'b0}};
  assign dataOutB = head_valid_s ? head_ent_s.db : {DW{1'b0}};
  assign labelOut = head_valid_s ? {head_ent_s.lb, head_ent_s.la} : {(2*LW){1'b0}};

  // Build the incoming entry, bypassing any broadcast of its producer labels.
  always_comb begin
    push_ent_s    = {$bits(entry_t){1'b0}};
    push_ent_s.op = opIN;
    {push_ent_s.la, push_ent_s.da} = snoop_operand(labelInA, dataInA, BCEN, BClabel, BCdata);
    {push_ent_s.lb, push_ent_s.db} = snoop_operand(labelInB, dataInB, BCEN, BClabel, BCdata);
  end

  // Next-state: snoop all valid entries, then apply pop, push and count update.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ent_d   = ent_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (valid_q[e]) begin
        {ent_d[e].la, ent_d[e].da} = snoop_operand(ent_q[e].la, ent_q[e].da, BCEN, BClabel, BCdata);
        {ent_d[e].lb, ent_d[e].db} = snoop_operand(ent_q[e].lb, ent_q[e].db, BCEN, BClabel, BCdata);
      end else begin
        ent_d[e] = ent_q[e];
      end
    end
    if (flush_s) begin
      valid_d = {DEPTH{1'b0}};
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + AW'(1);
      end else begin
        head_d = head_q;
      end
      if (push_s) begin
        ent_d[tail_q]   = push_ent_s;
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + AW'(1);
      end else begin
        tail_d = tail_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous clear of occupancy and storage.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      valid_q <= {DEPTH{1'b0}};
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      for (int e = 0; e < DEPTH; e++) begin
        ent_q[e] <= {$bits(entry_t){1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int e = 0; e < DEPTH; e++) begin
        ent_q[e] <= ent_d[e];
      end
    end
  end

endmodule

// File: tb/tb_tagged_operand_queue.sv
// Directed bench for tagged_operand_queue (default parameters).
module tb_tagged_operand_queue;

  localparam int DW = 32;
  localparam int LW = 5;
  localparam int OPW = 4;
  localparam int DEPTH = 8;
  localparam int NUM_BC = 2;

  logic                 clk;
  logic                 nRST;
  logic                 flush;
  logic                 WEN;
  logic [OPW-1:0]       opIN;
  logic [DW-1:0]        dataInA, dataInB;
  logic [LW-1:0]        labelInA, labelInB;
  logic                 isFull;
  logic [3:0]           count;
  logic [NUM_BC-1:0]    BCEN;
  logic [NUM_BC*LW-1:0] BClabel;
  logic [NUM_BC*DW-1:0] BCdata;
  logic                 require;
  logic                 requireAC;
  logic [OPW-1:0]       opOut;
  logic [DW-1:0]        dataOutA, dataOutB;
  logic [2*LW-1:0]      labelOut;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  tagged_operand_queue #(.DW(DW), .LW(LW), .OPW(OPW), .DEPTH(DEPTH), .NUM_BC(NUM_BC)) dut (
    .clk(clk), .nRST(nRST),
`ifdef TAGGED_QUEUE_FLUSH_EN
    .flush(flush),
`endif
    .WEN(WEN), .opIN(opIN), .dataInA(dataInA), .labelInA(labelInA),
    .dataInB(dataInB), .labelInB(labelInB), .isFull(isFull), .count(count),
    .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata), .require(require),
    .requireAC(requireAC), .opOut(opOut), .dataOutA(dataOutA), .dataOutB(dataOutB),
    .labelOut(labelOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_push(input int op, input int da, input int la, input int db, input int lb);
    WEN = 1'b1;
    opIN = op[OPW-1:0];
    dataInA = da[DW-1:0];
    labelInA = la[LW-1:0];
    dataInB = db[DW-1:0];
    labelInB = lb[LW-1:0];
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; WEN = 1'b0; opIN = 4'd0;
    dataInA = 32'd0; labelInA = 5'd0; dataInB = 32'd0; labelInB = 5'd0;
    BCEN = 2'b00; BClabel = 10'd0; BCdata = 64'd0; requireAC = 1'b0;
    #12;
    chk("rst_full", isFull, 0);
    chk("rst_require", require, 0);
    chk("rst_count", count, 0);
    chk("rst_opOut", opOut, 0);
    chk("rst_dataOutA", dataOutA, 0);
    chk("rst_labelOut", labelOut, 0);
    nRST = 1'b1;

    // Resolved push then pop
    set_push(1, 20, 0, 7, 0);
    tick();
    WEN = 1'b0;
    chk("t1_require", require, 1);
    chk("t1_opOut", opOut, 1);
    chk("t1_dataOutA", dataOutA, 20);
    chk("t1_dataOutB", dataOutB, 7);
    chk("t1_labelOut", labelOut, 0);
    chk("t1_count", count, 1);
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;
    chk("t1_empty_require", require, 0);
    chk("t1_empty_count", count, 0);
    chk("t1_empty_dataOutA", dataOutA, 0);
    chk("t1_empty_opOut", opOut, 0);

    // Two-stage resolution via ch0 then ch1
    set_push(2, 32'hdead, 4, 32'hbeef, 5);
    tick();
    WEN = 1'b0;
    chk("t2_require0", require, 0);
    chk("t2_labelOut0", labelOut, {5'd5, 5'd4});
    chk("t2_count", count, 1);
    BCEN = 2'b01; BClabel = {5'd0, 5'd4}; BCdata = {32'd0, 32'd25};
    tick();
    BCEN = 2'b00;
    chk("t2_require1", require, 0);
    chk("t2_dataOutA", dataOutA, 25);
    chk("t2_labelOut1", labelOut, {5'd5, 5'd0});
    BCEN = 2'b10; BClabel = {5'd5, 5'd0}; BCdata = {32'd9, 32'd0};
    #1;
    chk("t2_require_same_cycle", require, 0);
    tick();
    BCEN = 2'b00;
    chk("t2_require2", require, 1);
    chk("t2_dataOutA2", dataOutA, 25);
    chk("t2_dataOutB2", dataOutB, 9);
    chk("t2_labelOut2", labelOut, 0);
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;
    chk("t2_count_after_pop", count, 0);

    // Write bypass from ch1
    set_push(3, 0, 3, 1, 0);
    BCEN = 2'b10; BClabel = {5'd3, 5'd0}; BCdata = {32'd11, 32'd0};
    tick();
    WEN = 1'b0; BCEN = 2'b00;
    chk("t3_require", require, 1);
    chk("t3_dataOutA", dataOutA, 11);
    chk("t3_dataOutB", dataOutB, 1);
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;

    // Label-0 broadcast must not disturb a resolved push
    set_push(4, 5, 0, 6, 0);
    BCEN = 2'b01; BClabel = {5'd0, 5'd0}; BCdata = {32'd0, 32'd77};
    tick();
    WEN = 1'b0; BCEN = 2'b00;
    chk("t3b_dataOutA", dataOutA, 5);
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;

    // Both channels on label 6: lowest channel wins; A and B share label
    set_push(5, 0, 6, 0, 6);
    tick();
    WEN = 1'b0;
    BCEN = 2'b11; BClabel = {5'd6, 5'd6}; BCdata = {32'd200, 32'd100};
    tick();
    BCEN = 2'b00;
    chk("t4_require", require, 1);
    chk("t4_dataOutA", dataOutA, 100);
    chk("t4_dataOutB", dataOutB, 100);
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;
    chk("t4_count", count, 0);

    // Fill to full
    for (int i = 0; i < DEPTH; i++) begin
      set_push(i, 10 + i, 0, 0, 0);
      tick();
      exp_q.push_back(10 + i);
    end
    WEN = 1'b0;
    chk("t5_isFull", isFull, 1);
    chk("t5_count", count, 8);
    // Push with pop on a full queue: push dropped
    set_push(15, 99, 0, 0, 0);
    requireAC = 1'b1;
    tick();
    void'(exp_q.pop_front());
    WEN = 1'b0; requireAC = 1'b0;
    chk("t5_count_after", count, 7);
    chk("t5_isFull_after", isFull, 0);
    // Wrap pointers with steady push/pop
    for (int k = 0; k < 20; k++) begin
      chk("t5_fifo_order", dataOutA, exp_q[0]);
      set_push(k, 100 + k, 0, 0, 0);
      requireAC = 1'b1;
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(100 + k);
    end
    WEN = 1'b0;
    chk("t5_count_wrap", count, 7);
    chk("t5_head_after_wrap", dataOutA, exp_q[0]);
    tick();
    tick();
    requireAC = 1'b0;
    chk("t6_count5", count, 5);
    chk("t6_require_pre", require, 1);

    // Asynchronous reset mid-stream
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_isFull", isFull, 0);
    chk("t6_require", require, 0);
    chk("t6_count", count, 0);
    #1;
    nRST = 1'b1;
    tick();
    chk("t6_count_post", count, 0);

`ifdef TAGGED_QUEUE_FLUSH_EN
    set_push(1, 1, 0, 0, 0);
    tick();
    set_push(2, 2, 0, 0, 0);
    tick();
    chk("t7_count2", count, 2);
    set_push(3, 3, 0, 0, 0);
    flush = 1'b1;
    #1;
    chk("t7_require_forced", require, 0);
    tick();
    flush = 1'b0; WEN = 1'b0;
    chk("t7_count", count, 0);
    chk("t7_require", require, 0);
    chk("t7_dataOutA", dataOutA, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
